// File: rtl/memory_stage.sv
// Y86-64 memory stage: E->M pipeline register, byte-addressed little-endian data
// memory with 8-byte accesses, and the address-check/status logic that feeds write-back.
module memory_stage #(
   parameter int MEM_BYTES = 1024,
   parameter int ADDR_W    = 64
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        M_bubble,
   input  logic [3:0]  e_icode,
   input  logic [1:0]  e_status,
   input  logic        e_cnd,
   input  logic [63:0] e_vale,
   input  logic [63:0] e_vala,
   input  logic [3:0]  e_dste,
   input  logic [3:0]  e_dstm,
   output logic [3:0]  M_icode,
   output logic [1:0]  M_status,
   output logic        M_cnd,
   output logic [63:0] M_vale,
   output logic [63:0] M_vala,
   output logic [3:0]  M_dste,
   output logic [3:0]  M_dstm,
   output logic [63:0] m_valm,
   output logic [1:0]  m_status
);

   localparam int              IDX_W    = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
   localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 8);

   localparam logic [3:0] I_NOP    = 4'd1;
   localparam logic [3:0] I_RMMOVQ = 4'd4;
   localparam logic [3:0] I_MRMOVQ = 4'd5;
   localparam logic [3:0] I_CALL   = 4'd8;
   localparam logic [3:0] I_RET    = 4'd9;
   localparam logic [3:0] I_PUSHQ  = 4'd10;
   localparam logic [3:0] I_POPQ   = 4'd11;
   localparam logic [3:0] R_NONE   = 4'd15;

   localparam logic [1:0] S_AOK = 2'b00;
   localparam logic [1:0] S_ADR = 2'b10;

   logic [3:0]  icode_q,  icode_d;
   logic [1:0]  status_q, status_d;
   logic        cnd_q,    cnd_d;
   logic [63:0] vale_q,   vale_d;
   logic [63:0] vala_q,   vala_d;
   logic [3:0]  dste_q,   dste_d;
   logic [3:0]  dstm_q,   dstm_d;

   logic [7:0]        mem_q [MEM_BYTES];
   logic [ADDR_W-1:0] addr;
   logic [IDX_W-1:0]  idx [8];
   logic [63:0]       rd_word;
   logic              rd_req;
   logic              wr_req;
   logic              addr_ok;
   logic              wr_en;

   // Reset and bubble both inject a nop with no destinations.
   always_comb begin
      icode_d  = e_icode;
      status_d = e_status;
      cnd_d    = e_cnd;
      vale_d   = e_vale;
      vala_d   = e_vala;
      dste_d   = e_dste;
      dstm_d   = e_dstm;
      if (!reset_n || M_bubble) begin
         icode_d  = I_NOP;
         status_d = S_AOK;
         cnd_d    = 1'b0;
         vale_d   = '0;
         vala_d   = '0;
         dste_d   = R_NONE;
         dstm_d   = R_NONE;
      end
   end

   always_ff @(posedge clock) begin
      icode_q  <= icode_d;
      status_q <= status_d;
      cnd_q    <= cnd_d;
      vale_q   <= vale_d;
      vala_q   <= vala_d;
      dste_q   <= dste_d;
      dstm_q   <= dstm_d;
   end

   always_comb begin
      rd_req = 1'b0;
      wr_req = 1'b0;
      addr   = vale_q[ADDR_W-1:0];
      unique case (icode_q)
         I_RMMOVQ, I_CALL, I_PUSHQ: wr_req = 1'b1;
         I_MRMOVQ:                  rd_req = 1'b1;
         I_RET, I_POPQ: begin
            rd_req = 1'b1;
            addr   = vala_q[ADDR_W-1:0];
         end
         default: ;
      endcase
   end

   // Full-width unsigned compare, so addresses near 2^64 never wrap into range.
   assign addr_ok = (addr <= MAX_ADDR);
   assign wr_en   = reset_n && wr_req && addr_ok && (status_q == S_AOK);

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_lane
         assign idx[gi] = IDX_W'(addr[IDX_W-1:0] + IDX_W'(gi));
         assign rd_word[8*gi +: 8] = mem_q[idx[gi]];
      end
   endgenerate

   // Contents survive reset; all eight bytes commit together or not at all.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int i = 0; i < 8; i++) begin
            mem_q[idx[i]] <= vala_q[8*i +: 8];
         end
      end
   end

   assign m_valm   = (rd_req && addr_ok) ? rd_word : 64'd0;
   assign m_status = ((rd_req || wr_req) && !addr_ok) ? S_ADR : status_q;

   assign M_icode  = icode_q;
   assign M_status = status_q;
   assign M_cnd    = cnd_q;
   assign M_vale   = vale_q;
   assign M_vala   = vala_q;
   assign M_dste   = dste_q;
   assign M_dstm   = dstm_q;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized scoreboard bench for memory_stage: a byte-array reference model predicts
// each M-stage result at issue time; a monitor compares one cycle later.
module tb_memory_stage;

   typedef struct {
      logic [3:0]  icode;
      logic [1:0]  status;
      logic        cnd;
      logic [63:0] vale;
      logic [63:0] vala;
      logic [3:0]  dste;
      logic [3:0]  dstm;
      logic [63:0] valm;
      logic [1:0]  mstat;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        M_bubble = 1'b0;
   logic [3:0]  e_icode = 4'd1;
   logic [1:0]  e_status = 2'd0;
   logic        e_cnd = 1'b0;
   logic [63:0] e_vale = '0;
   logic [63:0] e_vala = '0;
   logic [3:0]  e_dste = 4'd15;
   logic [3:0]  e_dstm = 4'd15;
   logic [3:0]  M_icode;
   logic [1:0]  M_status;
   logic        M_cnd;
   logic [63:0] M_vale;
   logic [63:0] M_vala;
   logic [3:0]  M_dste;
   logic [3:0]  M_dstm;
   logic [63:0] m_valm;
   logic [1:0]  m_status;

   int   n_checks = 0;
   int   n_fail = 0;
   int   n_txn = 0;
   exp_t exp_q[$];
   exp_t mdl;
   logic [7:0] ref_mem [1024];

   memory_stage #(.MEM_BYTES(1024), .ADDR_W(64)) dut (
      .clock(clock), .reset_n(reset_n), .M_bubble(M_bubble),
      .e_icode(e_icode), .e_status(e_status), .e_cnd(e_cnd),
      .e_vale(e_vale), .e_vala(e_vala), .e_dste(e_dste), .e_dstm(e_dstm),
      .M_icode(M_icode), .M_status(M_status), .M_cnd(M_cnd),
      .M_vale(M_vale), .M_vala(M_vala), .M_dste(M_dste), .M_dstm(M_dstm),
      .m_valm(m_valm), .m_status(m_status)
   );

   always #5 clock = ~clock;

   function automatic bit reads(logic [3:0] ic);
      return ic inside {4'd5, 4'd9, 4'd11};
   endfunction

   function automatic bit writes(logic [3:0] ic);
      return ic inside {4'd4, 4'd8, 4'd10};
   endfunction

   function automatic logic [63:0] addr_of(exp_t x);
      return (x.icode inside {4'd9, 4'd11}) ? x.vala : x.vale;
   endfunction

   function automatic bit in_range(logic [63:0] a);
      return a <= 64'd1016;
   endfunction

   function automatic exp_t bubble_rec();
      exp_t b;
      b.icode = 4'd1; b.status = 2'd0; b.cnd = 1'b0; b.vale = '0; b.vala = '0;
      b.dste = 4'd15; b.dstm = 4'd15; b.valm = '0; b.mstat = 2'd0;
      return b;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, want);
      end
   endtask

   // One cycle: drive e_* at the falling edge and advance the reference model.
   task automatic step(input logic rst_n, input logic bub, input logic [3:0] ic,
                       input logic [1:0] st, input logic cnd, input logic [63:0] ve,
                       input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
      exp_t nx;
      logic [63:0] a;
      @(negedge clock);
      reset_n = rst_n; M_bubble = bub; e_icode = ic; e_status = st; e_cnd = cnd;
      e_vale = ve; e_vala = va; e_dste = de; e_dstm = dm;
      a = addr_of(mdl);
      if (rst_n && mdl.status == 2'd0 && writes(mdl.icode) && in_range(a))
         for (int k = 0; k < 8; k++) ref_mem[a[9:0] + 10'(k)] = mdl.vala[8*k +: 8];
      if (!rst_n || bub) nx = bubble_rec();
      else begin
         nx.icode = ic; nx.status = st; nx.cnd = cnd; nx.vale = ve; nx.vala = va;
         nx.dste = de; nx.dstm = dm;
      end
      a = addr_of(nx);
      nx.valm = '0;
      if (reads(nx.icode) && in_range(a))
         for (int k = 0; k < 8; k++) nx.valm[8*k +: 8] = ref_mem[a[9:0] + 10'(k)];
      nx.mstat = ((reads(nx.icode) || writes(nx.icode)) && !in_range(a)) ? 2'b10 : nx.status;
      mdl = nx;
      exp_q.push_back(nx);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_txn++;
            $display("txn %0d: icode=%0d st=%0d vale=%h vala=%h dstE=%0d dstM=%0d valm=%h mstat=%0d",
                     n_txn, M_icode, M_status, M_vale, M_vala, M_dste, M_dstm, m_valm, m_status);
            chk("M_icode", 64'(M_icode), 64'(e.icode));
            chk("M_status", 64'(M_status), 64'(e.status));
            chk("M_cnd", 64'(M_cnd), 64'(e.cnd));
            chk("M_vale", M_vale, e.vale);
            chk("M_vala", M_vala, e.vala);
            chk("M_dste", 64'(M_dste), 64'(e.dste));
            chk("M_dstm", 64'(M_dstm), 64'(e.dstm));
            chk("m_valm", m_valm, e.valm);
            chk("m_status", 64'(m_status), 64'(e.mstat));
         end
      end
   end

   initial begin : stimulus
      logic [3:0]  ic;
      logic [1:0]  st;
      logic [63:0] ve, va;
      mdl = bubble_rec();
      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
      // Reset held two cycles while execute presents a store.
      step(1'b0, 1'b0, 4'd4, 2'd0, 1'b0, 64'h40, 64'hAA, 4'd15, 4'd15);
      step(1'b0, 1'b0, 4'd4, 2'd0, 1'b0, 64'h40, 64'hAA, 4'd15, 4'd15);
      // Fill the whole memory so every later read is defined.
      for (int i = 0; i < 128; i++)
         step(1'b1, 1'b0, 4'd4, 2'd0, 1'b0, 64'(8 * i), {$urandom, $urandom}, 4'd15, 4'd15);
      // Store then load, including an offset read whose LSB is byte 0x47.
      step(1'b1, 1'b0, 4'd4, 2'd0, 1'b0, 64'h40, 64'h1122334455667788, 4'd15, 4'd15);
      step(1'b1, 1'b0, 4'd5, 2'd0, 1'b0, 64'h40, 64'h0, 4'd15, 4'd3);
      step(1'b1, 1'b0, 4'd5, 2'd0, 1'b0, 64'h47, 64'h0, 4'd15, 4'd3);
      // Push addressed by valE, pop addressed by valA.
      step(1'b1, 1'b0, 4'd10, 2'd0, 1'b0, 64'h1F8, 64'h5, 4'd4, 4'd15);
      step(1'b1, 1'b0, 4'd11, 2'd0, 1'b0, 64'h200, 64'h1F8, 4'd4, 4'd7);
      step(1'b1, 1'b0, 4'd8, 2'd0, 1'b0, 64'h1F0, 64'h123, 4'd4, 4'd15);
      step(1'b1, 1'b0, 4'd9, 2'd0, 1'b0, 64'h1F8, 64'h1F0, 4'd4, 4'd15);
      // Address boundary and wrap-around.
      step(1'b1, 1'b0, 4'd5, 2'd0, 1'b1, 64'h3F8, 64'h0, 4'd15, 4'd2);
      step(1'b1, 1'b0, 4'd5, 2'd0, 1'b0, 64'h3F9, 64'h0, 4'd15, 4'd2);
      step(1'b1, 1'b0, 4'd4, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hDEAD_BEEF_CAFE_F00D, 4'd15, 4'd15);
      step(1'b1, 1'b0, 4'd5, 2'd0, 1'b0, 64'h0, 64'h0, 4'd15, 4'd1);
      // Bubble over a store, then read the target.
      step(1'b1, 1'b1, 4'd4, 2'd0, 1'b0, 64'h80, 64'h0BAD_0BAD_0BAD_0BAD, 4'd15, 4'd15);
      step(1'b1, 1'b0, 4'd5, 2'd0, 1'b0, 64'h80, 64'h0, 4'd15, 4'd1);
      // Non-AOK status passes through and blocks the write.
      step(1'b1, 1'b0, 4'd10, 2'd3, 1'b0, 64'h100, 64'h7777, 4'd4, 4'd15);
      step(1'b1, 1'b0, 4'd5, 2'd0, 1'b0, 64'h100, 64'h0, 4'd15, 4'd1);
      step(1'b1, 1'b0, 4'd0, 2'd1, 1'b0, 64'h0, 64'h0, 4'd15, 4'd15);
      // Store in M when reset arrives must not commit.
      step(1'b1, 1'b0, 4'd4, 2'd0, 1'b0, 64'h60, 64'h5555_6666_7777_8888, 4'd15, 4'd15);
      step(1'b0, 1'b0, 4'd4, 2'd0, 1'b0, 64'h60, 64'hAA, 4'd15, 4'd15);
      step(1'b0, 1'b0, 4'd4, 2'd0, 1'b0, 64'h60, 64'hAA, 4'd15, 4'd15);
      step(1'b1, 1'b0, 4'd5, 2'd0, 1'b0, 64'h60, 64'h0, 4'd15, 4'd1);
      // Random traffic biased towards colliding memory operations.
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: ic = 4'd4;
            3, 4:    ic = 4'd5;
            5:       ic = 4'(8 + $urandom_range(0, 3));
            6:       ic = 4'd5;
            default: ic = 4'($urandom_range(0, 15));
         endcase
         st = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         case ($urandom_range(0, 9))
            0:       ve = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
            1:       ve = 64'(1016 + $urandom_range(0, 7));
            default: ve = 64'($urandom_range(0, 127) * 8 + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0));
         endcase
         va = (ic inside {4'd9, 4'd11}) ? 64'($urandom_range(0, 1023)) : {$urandom, $urandom};
         step(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) == 0), ic, st,
              1'($urandom), ve, va, 4'($urandom), 4'($urandom));
      end
      step(1'b1, 1'b1, 4'd1, 2'd0, 1'b0, 64'h0, 64'h0, 4'd15, 4'd15);
      @(negedge clock);
      @(negedge clock);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Y86-64 pipeline memory stage. Directly downstream of the execute stage.
- Contains the E->M pipeline register (M_* state), a byte-addressed little-endian data memory, and the memory-status logic.
- Consumes the execute outputs (e_icode, e_status, e_vale, e_vala, e_dste, e_dstm, e_cnd).
- Produces M_* values for forwarding and the write-back register, plus m_valm and m_status.

Parameters:
- MEM_BYTES, 1024, data memory size in bytes; valid addresses 0..MEM_BYTES-1.
- ADDR_W, 64, address width; addresses are compared at the full 64-bit width.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- M_bubble  in  1  from hazard control: load a bubble instead of e_* at the next edge
- e_icode  in  4  instruction code from execute
- e_status  in  2  status from execute: 00 AOK, 01 HLT, 10 ADR, 11 INS
- e_cnd  in  1  condition result from execute
- e_vale  in  64  ALU result from execute
- e_vala  in  64  valA from execute
- e_dste  in  4  destination register for valE (15 = none)
- e_dstm  in  4  destination register for valM (15 = none)
- M_icode  out  4  registered icode
- M_status  out  2  registered status
- M_cnd  out  1  registered condition
- M_vale  out  64  registered valE
- M_vala  out  64  registered valA
- M_dste  out  4  registered dstE
- M_dstm  out  4  registered dstM
- m_valm  out  64  data read from memory (combinational from M_*)
- m_status  out  2  stage status after the memory check (combinational)

Behaviour:
- Clocking: all state changes on the rising clock edge. Reset is synchronous and active-low.
- Reset: reset_n=0 at an edge loads the bubble state into the M register:
  - M_icode=1 (nop), M_status=00, M_cnd=0, M_vale=0, M_vala=0, M_dste=15, M_dstm=15.
  - Memory contents are not cleared by reset.
  - A write pending in the same cycle as reset is suppressed.
- Pipeline register, reset_n=1:
  - M_bubble=1: load the bubble state (same values as reset).
  - Otherwise: load e_* unchanged.
  - Latency is one cycle: e_* in cycle N appear on M_* in cycle N+1.
  - There is no stall input; the M register advances every cycle.
- Address select, from M_icode:
  - 4 (rmmovq), 5 (mrmovq), 8 (call), 10 (pushq): address = M_vale.
  - 9 (ret), 11 (popq): address = M_vala.
  - Any other icode: no memory access.
- Reads: icode 5, 9 and 11 read.
  - m_valm = 8 bytes at address..address+7, little-endian (address holds the LSB).
  - Combinational within the cycle.
  - m_valm = 0 when no read occurs or the address is invalid.
- Writes: icode 4, 8 and 10 write M_vala as 8 little-endian bytes at address..address+7.
  - Committed at the rising edge that ends the cycle the instruction occupies M.
  - A read of the same address in the next cycle returns the new data.
- Address validity: an access is invalid if address > MEM_BYTES-8, using a 64-bit unsigned compare. This covers wrap-around: address 0xFFFF_FFFF_FFFF_FFFC is invalid, with no modular wrap.
- Invalid access:
  - m_status = 10 (ADR).
  - No bytes are written (not even partially).
  - m_valm = 0.
- Status:
  - If the access is invalid, m_status = ADR.
  - Otherwise m_status = M_status. An incoming HLT/INS/ADR passes through.
- Non-AOK entry: if M_status != 00 on entry, no write is performed, regardless of icode.
- M_cnd, M_dste and M_dstm pass through unmodified.
  - The stage does not alter dste; the conditional-move cancellation already happened upstream.
- Simultaneous events:
  - reset_n=0 overrides M_bubble.
  - A store in M at the same edge that a load is latched into M is legal. The store commits at that edge, and the load reads the updated memory in the following cycle.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with e_icode=4 and e_vala=0xAA -> M_icode=1, M_dste=M_dstm=15, m_status=00; memory at e_vale stays unchanged.
- Store then load: rmmovq with e_vale=0x40, e_vala=0x1122334455667788, then mrmovq with e_vale=0x40 -> second instruction's m_valm=0x1122334455667788; byte 0x40 = 0x88, byte 0x47 = 0x11.
- Push/pop path: pushq with e_vale=0x1F8, e_vala=0x5 (addressed by vale); next popq with e_vala=0x1F8 (addressed by vala) -> m_valm=0x5, M_dstm passed through.
- Boundary: mrmovq at 0x3F8 -> AOK. At 0x3F9 -> m_status=10, m_valm=0. rmmovq at 0xFFFF_FFFF_FFFF_FFFC -> ADR and no bytes changed at 0x0..0x3.
- Bubble: M_bubble=1 while e_icode=4 -> next cycle M_icode=1 and no memory write.
- Status pass-through: e_status=11 with e_icode=10 -> m_status=11 and no write; e_status=01 with icode 0 -> m_status=01.
